// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the ft_pattern_seq test-pattern block.
// Holds the run mode and FSM state encodings, LFSR taps, mode seeds, the
// default run length, and the per-tick pattern update function.
package ft_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT    = 2'd0,
        MODE_LFSR     = 2'd1,
        MODE_WALK     = 2'd2,
        MODE_LOOPBACK = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  LFSR_TAPS       = 8'hB8;
    localparam logic [7:0]  SEED_COUNT      = 8'h00;
    localparam logic [7:0]  SEED_LFSR       = 8'h01;
    localparam logic [7:0]  SEED_WALK       = 8'h01;
    localparam int unsigned DEFAULT_RUN_LEN = 256;
    localparam int unsigned DIV_W           = 4;

    // Value loaded into the pattern register when a run starts.
    function automatic logic [7:0] seed_for(input mode_t m);
        logic [7:0] s;
        s = SEED_COUNT;
        case (m)
            MODE_LFSR: s = SEED_LFSR;
            MODE_WALK: s = SEED_WALK;
            default:   s = SEED_COUNT;
        endcase
        return s;
    endfunction

    // Pattern value after one tick; LOOPBACK shares the COUNT sequence.
    function automatic logic [7:0] next_pattern(input mode_t m, input logic [7:0] p);
        logic [7:0] n;
        n = p + 8'd1;
        case (m)
            MODE_LFSR: n = (p >> 1) ^ (p[0] ? LFSR_TAPS : 8'h00);
            MODE_WALK: n = {p[6:0], p[7]};
            default:   n = p + 8'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ft_prescaler.sv
// ft_prescaler: tick generator; tick pulses on every (div+1)-th enabled clock.
// The counter holds while enable is low so a frozen run resumes exactly.
module ft_prescaler
    import ft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,
    input  logic             enable,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = enable && (cnt == div);

    // Count enabled clocks, wrapping to zero on the tick clock.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ft_pattern_seq.sv
// ft_pattern_seq: built-in test pattern sequencer (COUNT / LFSR / WALK / LOOPBACK).
// Optional feature macro: FT_LOOPBACK_EN enables LOOPBACK checking and err_cnt;
// without it mode 3 runs as COUNT, loop_oe and err_cnt stay zero.
module ft_pattern_seq
    import ft_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned RUN_LEN = DEFAULT_RUN_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] loop_in,
    output logic [WIDTH-1:0] pat_out,
    output logic             loop_oe,
    output logic [7:0]       err_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int unsigned TCW = (RUN_LEN > 2) ? $clog2(RUN_LEN) : 1;

    state_t           state_q, state_d;
    mode_t            mode_q;
    mode_t            mode_sel;
    logic [DIV_W-1:0] div_q;
    logic [TCW-1:0]   tick_cnt;
    logic             load;
    logic             run_en;
    logic             tick;
    logic             last_tick;

    assign run_en    = ena && (state_q == ST_RUN);
    assign last_tick = (tick_cnt == TCW'(RUN_LEN - 1));

`ifdef FT_LOOPBACK_EN
    assign mode_sel = mode_t'(mode);
`else
    assign mode_sel = (mode_t'(mode) == MODE_LOOPBACK) ? MODE_COUNT : mode_t'(mode);
`endif

    ft_prescaler u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .div    (div_q),
        .clear  (load),
        .enable (run_en),
        .tick   (tick)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status outputs; ena gates every transition.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        busy    = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        pass    = (state_q == ST_DONE) && (err_cnt == 8'h00);
`ifdef FT_LOOPBACK_EN
        loop_oe = (state_q == ST_RUN) && (mode_q == MODE_LOOPBACK);
`else
        loop_oe = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ena && start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick && last_tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ena && !start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run configuration latch, tick counter and pattern register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_COUNT;
            div_q    <= '0;
            tick_cnt <= '0;
            pat_out  <= '0;
        end else if (load) begin
            mode_q   <= mode_sel;
            div_q    <= div;
            tick_cnt <= '0;
            pat_out  <= seed_for(mode_sel);
        end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            pat_out  <= next_pattern(mode_q, pat_out);
        end
    end

`ifdef FT_LOOPBACK_EN
    // Loopback mismatch counter; compares against the pattern before it advances.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            err_cnt <= '0;
        end else if (tick && (mode_q == MODE_LOOPBACK) &&
                     (loop_in != pat_out) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_loop_in;
    assign unused_loop_in = ^loop_in;
    assign err_cnt        = '0;
`endif

endmodule

// File: doc/ft_pattern_seq.md
FT_PATTERN_SEQ -- requirements
Module: ft_pattern_seq

Interface
REQ-001 Parameter WIDTH, default 8, pattern/bus width; only 8 is supported.
REQ-002 Parameter RUN_LEN, default 256, number of pattern ticks per run.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ena  input  1  design enable; low freezes all state.
REQ-006 start  input  1  run request, level; sampled in IDLE/DONE only.
REQ-007 mode  input  2  0=COUNT, 1=LFSR, 2=WALK, 3=LOOPBACK; latched at run start.
REQ-008 div  input  4  tick prescaler; tick every div+1 enabled clocks; latched at run start.
REQ-009 loop_in  input  8  returned pattern from external loopback.
REQ-010 pat_out  output  8  registered test pattern.
REQ-011 loop_oe  output  1  high while a LOOPBACK run is active.
REQ-012 err_cnt  output  8  loopback mismatch count, saturating.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.
REQ-015 pass  output  1  valid in DONE: high iff err_cnt==0.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN when start=1 and ena=1; RUN->DONE on the clock of the RUN_LEN-th tick; DONE->IDLE when start=0.
REQ-017 On IDLE->RUN: mode, div latched; tick counter, prescaler, err_cnt cleared; pat_out loaded with mode seed (COUNT/LOOPBACK 0x00, LFSR 0x01, WALK 0x01).
REQ-018 Tick: one-cycle pulse when prescaler reaches latched div; div=0 gives a tick every enabled clock in RUN.
REQ-019 ena=0: no tick, no state change, outputs hold; resumes exactly where frozen.
REQ-020 COUNT/LOOPBACK: pat_out+1 per tick, 0xFF wraps to 0x00.
REQ-021 LFSR: Galois right-shift, taps 0xB8; next = (p>>1) ^ (p[0] ? 0xB8 : 0); period 255, never reaches 0x00.
REQ-022 WALK: rotate left by one per tick; 0x80 wraps to 0x01.
REQ-023 LOOPBACK: on each tick, before pat_out update, compare loop_in to pat_out; mismatch increments err_cnt; 0xFF holds.
REQ-024 Other modes never touch err_cnt; pass therefore 1 in DONE.
REQ-025 start changes during RUN are ignored; run always completes RUN_LEN ticks.
REQ-026 In DONE: pat_out, err_cnt hold last values; loop_oe=0; done=1 until DONE->IDLE.
REQ-027 start held high through DONE->IDLE is not a new request; a fresh run needs start low then high.

Reset
REQ-028 rst=1 on any clock, any state (incl. mid-run): state IDLE; pat_out 0x00, loop_oe 0, err_cnt 0x00, busy 0, done 0, pass 0; counters cleared; rst overrides ena.

Configuration
REQ-029 Macro FT_LOOPBACK_EN defined: LOOPBACK mode and err_cnt logic as above.
REQ-030 FT_LOOPBACK_EN undefined: mode 3 behaves as COUNT, loop_oe tied 0, err_cnt tied 0x00, loop_in unused, pass=1 in DONE.

Structure
REQ-031 Package ft_pkg holds mode enum, FSM state enum, LFSR_TAPS=8'hB8, seed constants, default RUN_LEN.
REQ-032 Sub-module ft_prescaler (div input, clear, enable, tick output) holds the prescaler counter.

Verification
REQ-033 mode=0, div=0, start pulse -> pat_out 0x00,0x01,...,0xFF; done after 256 ticks, pat_out wraps to 0x00 on last tick, pass=1.
REQ-034 mode=1, div=0 -> pat_out 0x01,0xB8,0x5C,0x2E...; value 0x01 recurs at tick 255; never 0x00.
REQ-035 mode=2, div=3 -> tick every 4 clocks; pat_out 0x01,0x02,...,0x80,0x01; busy high 1024 clocks.
REQ-036 mode=3, loop_in=pat_out except forced 0x00 on 3 ticks -> err_cnt=3, pass=0; loop_in constant 0xAA -> err_cnt saturates at 0xFF.
REQ-037 ena low 10 clocks mid-run -> pat_out, counters frozen, run ends 10 clocks later; rst mid-run -> all outputs reset next clock, state IDLE.
